// File: rtl/apuf_ctrl_pkg.sv
// Shared definitions for the arbiter PUF sequencer: FSM encoding and
// counter-width helpers.
package apuf_ctrl_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_LAUNCH  = 3'd2;
    localparam logic [2:0] ST_RELEASE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    // Vote counter and ones counter must hold 0..VOTES.
    function automatic int vote_cnt_w(input int votes);
        return $clog2(votes + 1);
    endfunction

    // Settle timer must hold up to SETTLE_CYCLES+1 (the launch-high reload).
    function automatic int timer_w(input int settle);
        return $clog2(settle + 3);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for signals arriving asynchronously to clk,
// such as the arbiter response.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/apuf_ctrl.sv
// Arbiter PUF sequencer: applies a challenge, fires VOTES launch pulses,
// samples the synchronised response once per pulse and majority-votes it.
module apuf_ctrl
    import apuf_ctrl_pkg::*;
#(
    parameter int line_length   = 3,
    parameter int SETTLE_CYCLES = 4,
    parameter int VOTES         = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [line_length-1:0]       req_challenge,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic                         rsp_bit,
    output logic                         rsp_stable,
    output logic [$clog2(VOTES+1)-1:0]   rsp_ones,
    output logic [line_length-1:0]       puf_challenge,
    output logic                         puf_launch,
    input  logic                         puf_response
);

    localparam int VW = vote_cnt_w(VOTES);
    localparam int TW = timer_w(SETTLE_CYCLES);
    localparam logic [TW-1:0] T_SETTLE = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] T_LAUNCH = TW'(SETTLE_CYCLES + 1);

    if (VOTES < 1 || (VOTES % 2) == 0) begin : g_bad_votes
        $error("apuf_ctrl: VOTES must be odd and >= 1");
    end
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("apuf_ctrl: SETTLE_CYCLES must be >= 1");
    end

    logic                   resp_sync;
    logic [2:0]             state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [VW-1:0]          votes_q, votes_d;
    logic [VW-1:0]          ones_q, ones_d;
    logic [line_length-1:0] chal_q, chal_d;
    logic                   launch_q, launch_d;
    logic                   req_ready_q, req_ready_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_bit_q, rsp_bit_d;
    logic                   rsp_stable_q, rsp_stable_d;

    sync_2ff #(.WIDTH(1)) u_resp_sync (
        .clk (clk),
        .rst (rst),
        .d   (puf_response),
        .q   (resp_sync)
    );

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        votes_d      = votes_q;
        ones_d       = ones_q;
        chal_d       = chal_q;
        rsp_bit_d    = rsp_bit_q;
        rsp_stable_d = rsp_stable_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    chal_d  = req_challenge;
                    votes_d = '0;
                    ones_d  = '0;
                    timer_d = T_SETTLE;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (timer_q == '0) begin
                    timer_d = T_LAUNCH;
                    state_d = ST_LAUNCH;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_LAUNCH: begin
                // Final high cycle: the two-flop delay has just elapsed, so sample now.
                if (timer_q == '0) begin
                    ones_d  = ones_q + VW'(resp_sync);
                    votes_d = votes_q + VW'(1);
                    timer_d = T_SETTLE;
                    state_d = ST_RELEASE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_RELEASE: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else if (votes_q == VW'(VOTES)) begin
                    rsp_bit_d    = (ones_q > VW'(VOTES / 2));
                    rsp_stable_d = (ones_q == '0) || (ones_q == VW'(VOTES));
                    state_d      = ST_DONE;
                end else begin
                    timer_d = T_LAUNCH;
                    state_d = ST_LAUNCH;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Outputs are registered from the next state so the launch line is glitch-free.
        launch_d    = (state_d == ST_LAUNCH);
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            votes_q      <= '0;
            ones_q       <= '0;
            chal_q       <= '0;
            launch_q     <= 1'b0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_bit_q    <= 1'b0;
            rsp_stable_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            votes_q      <= votes_d;
            ones_q       <= ones_d;
            chal_q       <= chal_d;
            launch_q     <= launch_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_bit_q    <= rsp_bit_d;
            rsp_stable_q <= rsp_stable_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_bit       = rsp_bit_q;
    assign rsp_stable    = rsp_stable_q;
    assign rsp_ones      = ones_q;
    assign puf_challenge = chal_q;
    assign puf_launch    = launch_q;

endmodule

// File: tb/tb_apuf_ctrl.sv
// Directed bench for apuf_ctrl with a behavioural arbiter PUF model
// (lookup-table response or a scripted per-launch sequence).
module tb_apuf_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [2:0] req_challenge = 3'b000;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic       rsp_bit;
    logic       rsp_stable;
    logic [2:0] rsp_ones;
    logic [2:0] puf_challenge;
    logic       puf_launch;
    logic       puf_response = 1'b0;

    logic       c_req_valid = 1'b0;
    logic       c_req_ready;
    logic [2:0] c_req_challenge = 3'b000;
    logic       c_rsp_valid;
    logic       c_rsp_ready = 1'b0;
    logic       c_rsp_bit;
    logic       c_rsp_stable;
    logic [0:0] c_rsp_ones;
    logic [2:0] c_puf_challenge;
    logic       c_puf_launch;
    logic       c_puf_response = 1'b0;

    apuf_ctrl #(.line_length(3), .SETTLE_CYCLES(4), .VOTES(7)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_challenge(req_challenge),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_bit(rsp_bit),
        .rsp_stable(rsp_stable), .rsp_ones(rsp_ones),
        .puf_challenge(puf_challenge), .puf_launch(puf_launch), .puf_response(puf_response)
    );

    apuf_ctrl #(.line_length(3), .SETTLE_CYCLES(1), .VOTES(1)) u_corner (
        .clk(clk), .rst(rst),
        .req_valid(c_req_valid), .req_ready(c_req_ready), .req_challenge(c_req_challenge),
        .rsp_valid(c_rsp_valid), .rsp_ready(c_rsp_ready), .rsp_bit(c_rsp_bit),
        .rsp_stable(c_rsp_stable), .rsp_ones(c_rsp_ones),
        .puf_challenge(c_puf_challenge), .puf_launch(c_puf_launch), .puf_response(c_puf_response)
    );

    // PUF model: response is 1 for challenges 3'b101 and 3'b111 unless a scripted sequence is active.
    logic [7:0] lut = 8'b1010_0000;
    bit         use_seq = 1'b0;
    logic [6:0] seq_bits = 7'd0;
    int         seq_base = 0;
    int         launch_cnt = 0;

    always @(posedge puf_launch) begin
        int  k;
        logic r;
        k = launch_cnt - seq_base;
        if (use_seq && k >= 0 && k < 7) r = seq_bits[k];
        else r = lut[puf_challenge];
        launch_cnt = launch_cnt + 1;
        #2;
        puf_response = r;
    end

    always @(posedge c_puf_launch) begin
        #2;
        c_puf_response = lut[c_puf_challenge];
    end

    int n_vec = 0;
    int n_mis = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns just after the handshake edge (end of cycle 0).
    task automatic send_req(input logic [2:0] c);
        int i;
        i = 0;
        while (!req_ready && i < 50) begin
            @(negedge clk);
            i++;
        end
        check("req_ready_before_send", req_ready, 1);
        req_valid = 1'b1;
        req_challenge = c;
        @(posedge clk);
    endtask

    // Samples cycles 1.. until rsp_valid, checking launch pulse shape and latency.
    task automatic collect(input string tag);
        int n, pulses, first_hi, hrun, lrun, hmin, hmax, lmin, lmax;
        logic prev;
        bit seen;
        n = 0; pulses = 0; first_hi = 0; hrun = 0; lrun = 0;
        hmin = 999; hmax = 0; lmin = 999; lmax = 0;
        prev = 1'b0; seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (n == 1) req_valid = 1'b0;
            if (rsp_valid) begin
                seen = 1'b1;
            end else if (puf_launch) begin
                if (!prev) begin
                    pulses++;
                    if (pulses == 1) first_hi = n;
                    else begin
                        if (lrun < lmin) lmin = lrun;
                        if (lrun > lmax) lmax = lrun;
                    end
                    hrun = 0;
                end
                hrun++;
            end else begin
                if (prev) begin
                    if (hrun < hmin) hmin = hrun;
                    if (hrun > hmax) hmax = hrun;
                    lrun = 0;
                end
                lrun++;
            end
            prev = puf_launch;
        end
        check({tag, "_seen"}, seen, 1);
        check({tag, "_latency"}, n, 75);
        check({tag, "_pulses"}, pulses, 7);
        check({tag, "_first_launch"}, first_hi, 5);
        check({tag, "_high_min"}, hmin, 6);
        check({tag, "_high_max"}, hmax, 6);
        check({tag, "_low_min"}, lmin, 4);
        check({tag, "_low_max"}, lmax, 4);
    endtask

    task automatic check_rsp(input string tag, input int ones, input bit b, input bit s, input logic [2:0] c);
        check({tag, "_ones"}, rsp_ones, ones);
        check({tag, "_bit"}, rsp_bit, b);
        check({tag, "_stable"}, rsp_stable, s);
        check({tag, "_challenge"}, puf_challenge, c);
        check({tag, "_req_ready_busy"}, req_ready, 0);
    endtask

    task automatic release_rsp(input string tag);
        rsp_ready = 1'b1;
        @(negedge clk);
        check({tag, "_valid_drop"}, rsp_valid, 0);
        check({tag, "_ready_rise"}, req_ready, 1);
        rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic [2:0] chal;
        bit         use_seq;
        logic [6:0] seq;
        int         ones;
        bit         rbit;
        bit         stab;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int rises, n, bad;
        logic prev;
        bit seen;

        // seq bit k is the response to launch k (bit 0 first)
        vecs[0] = '{3'b101, 1'b0, 7'b0000000, 7, 1'b1, 1'b1};
        vecs[1] = '{3'b010, 1'b0, 7'b0000000, 0, 1'b0, 1'b1};
        vecs[2] = '{3'b011, 1'b1, 7'b1001101, 4, 1'b1, 1'b0};
        vecs[3] = '{3'b110, 1'b1, 7'b0010100, 2, 1'b0, 1'b0};
        vecs[4] = '{3'b001, 1'b1, 7'b0000111, 3, 1'b0, 1'b0};
        vecs[5] = '{3'b111, 1'b1, 7'b1111101, 6, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_req_ready", req_ready, 1);
            check("idle_rsp_valid", rsp_valid, 0);
            check("idle_launch", puf_launch, 0);
            check("idle_challenge", puf_challenge, 0);
        end
        check("reset_rsp_ones", rsp_ones, 0);
        check("reset_rsp_bit", rsp_bit, 0);
        check("reset_rsp_stable", rsp_stable, 0);

        for (int i = 0; i < 6; i++) begin
            use_seq = vecs[i].use_seq;
            seq_bits = vecs[i].seq;
            seq_base = launch_cnt;
            send_req(vecs[i].chal);
            collect($sformatf("vec%0d", i));
            check_rsp($sformatf("vec%0d", i), vecs[i].ones, vecs[i].rbit, vecs[i].stab, vecs[i].chal);
            release_rsp($sformatf("vec%0d", i));
        end

        // Backpressure with a competing request held throughout.
        use_seq = 1'b0;
        send_req(3'b101);
        collect("bp");
        check_rsp("bp", 7, 1'b1, 1'b1, 3'b101);
        req_valid = 1'b1;
        req_challenge = 3'b010;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check("bp_hold_valid", rsp_valid, 1);
            check("bp_hold_ones", rsp_ones, 7);
            check("bp_hold_bit", rsp_bit, 1);
            check("bp_hold_req_ready", req_ready, 0);
            check("bp_hold_challenge", puf_challenge, 3'b101);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_idle_valid", rsp_valid, 0);
        check("bp_idle_ready", req_ready, 1);
        check("bp_idle_challenge", puf_challenge, 3'b101);
        rsp_ready = 1'b0;
        @(posedge clk);
        collect("bp2");
        check_rsp("bp2", 0, 1'b0, 1'b1, 3'b010);
        release_rsp("bp2");

        // Reset during the third launch pulse.
        send_req(3'b101);
        rises = 0; n = 0; prev = 1'b0;
        while (rises < 3 && n < 200) begin
            @(negedge clk);
            n++;
            if (n == 1) req_valid = 1'b0;
            if (puf_launch && !prev) rises++;
            prev = puf_launch;
        end
        check("rst_mid_third_launch", rises, 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_launch", puf_launch, 0);
        check("rst_mid_req_ready", req_ready, 1);
        check("rst_mid_rsp_valid", rsp_valid, 0);
        check("rst_mid_challenge", puf_challenge, 0);
        check("rst_mid_ones", rsp_ones, 0);
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (rsp_valid || puf_launch || !req_ready) bad++;
        end
        check("rst_mid_quiet", bad, 0);
        use_seq = 1'b1;
        seq_bits = 7'b1001101;
        seq_base = launch_cnt;
        send_req(3'b011);
        collect("post_rst");
        check_rsp("post_rst", 4, 1'b1, 1'b0, 3'b011);
        release_rsp("post_rst");

        // VOTES=1, SETTLE_CYCLES=1 instance.
        for (int j = 0; j < 2; j++) begin
            check("corner_req_ready", c_req_ready, 1);
            c_req_challenge = (j == 0) ? 3'b101 : 3'b000;
            c_req_valid = 1'b1;
            @(posedge clk);
            n = 0; seen = 1'b0;
            while (!seen && n < 50) begin
                @(negedge clk);
                n++;
                if (n == 1) c_req_valid = 1'b0;
                if (c_rsp_valid) seen = 1'b1;
            end
            check("corner_latency", n, 6);
            check("corner_ones", c_rsp_ones, (j == 0) ? 1 : 0);
            check("corner_bit", c_rsp_bit, (j == 0) ? 1 : 0);
            check("corner_stable", c_rsp_stable, 1);
            c_rsp_ready = 1'b1;
            @(negedge clk);
            check("corner_valid_drop", c_rsp_valid, 0);
            c_rsp_ready = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
